// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage handshake and operand bundle
// between the pipeline and the M-extension unit.
interface muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            muldiv_en_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output muldiv_en_i,
        output funct3_i,
        output rs1_data_i,
        output rs2_data_i,
        output flush_i,
        input  stall_o,
        input  busy_o,
        input  valid_o,
        input  result_o
    );

    modport slave (
        input  muldiv_en_i,
        input  funct3_i,
        input  rs1_data_i,
        input  rs2_data_i,
        input  flush_i,
        output stall_o,
        output busy_o,
        output valid_o,
        output result_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, 1 bit per cycle.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG =
        {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic [2:0]          r_funct3;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_divisor;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_dividend;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic                r_ovf;
    logic                r_busy;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;

    logic                w_a_sgn;
    logic                w_b_sgn;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [2*XLEN-1:0]   w_sum;
    logic [2*XLEN-1:0]   w_prod_fin;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic                w_qbit;
    logic [XLEN-1:0]     w_rem_nx;
    logic [XLEN-1:0]     w_quo_nx;
    logic [XLEN-1:0]     w_q_fin;
    logic [XLEN-1:0]     w_r_fin;
    logic [XLEN-1:0]     w_div_res;
    logic [XLEN-1:0]     w_fast_res;

    // Operand signedness and magnitudes at the start cycle.
    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        if (bus.funct3_i[2]) begin
            w_a_sgn = !bus.funct3_i[0];
            w_b_sgn = !bus.funct3_i[0];
        end else begin
            w_a_sgn = (bus.funct3_i[1:0] != 2'b11);
            w_b_sgn = !bus.funct3_i[1];
        end
        w_a_neg = w_a_sgn & bus.rs1_data_i[XLEN-1];
        w_b_neg = w_b_sgn & bus.rs2_data_i[XLEN-1];
        w_a_mag = w_a_neg ? -bus.rs1_data_i
                          : bus.rs1_data_i;
        w_b_mag = w_b_neg ? -bus.rs2_data_i
                          : bus.rs2_data_i;
    end

    // One multiply step plus final sign fix and half select.
    always_comb begin
        w_sum = r_prod;
        if (r_mplier[0]) begin
            w_sum = r_prod + r_mcand;
        end
        w_prod_fin = r_neg_q ? -w_sum : w_sum;
        if (r_funct3[1:0] == 2'b00) begin
            w_mul_res = w_prod_fin[XLEN-1:0];
        end else begin
            w_mul_res = w_prod_fin[2*XLEN-1:XLEN];
        end
    end

    // One restoring-divide step plus sign fix and fast path.
    always_comb begin
        w_shift  = {r_rem, r_quo[XLEN-1]};
        w_diff   = w_shift - {1'b0, r_divisor};
        w_qbit   = !w_diff[XLEN];
        w_rem_nx = w_qbit ? w_diff[XLEN-1:0]
                          : w_shift[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], w_qbit};
        w_q_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_div_res = r_funct3[1] ? w_r_fin : w_q_fin;
        if (r_div0) begin
            w_fast_res = r_funct3[1] ? r_dividend
                                     : {XLEN{1'b1}};
        end else begin
            w_fast_res = r_funct3[1] ? {XLEN{1'b0}}
                                     : MIN_NEG;
        end
    end

    // Control FSM with datapath registers and outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_divisor  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
        end else if (bus.flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.muldiv_en_i) begin
                        r_funct3   <= bus.funct3_i;
                        r_mcand    <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier   <= w_b_mag;
                        r_prod     <= '0;
                        r_divisor  <= w_b_mag;
                        r_quo      <= w_a_mag;
                        r_rem      <= '0;
                        r_dividend <= bus.rs1_data_i;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div0     <= (bus.rs2_data_i == '0);
                        r_ovf      <= w_a_sgn
                            & (bus.rs1_data_i == MIN_NEG)
                            & (bus.rs2_data_i == '1);
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= bus.funct3_i[2] ? S_DIV
                                                      : S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod   <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_mul_res;
                    end
                end
                S_DIV: begin
                    if (r_div0 | r_ovf) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_fast_res;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_div_res;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and every iterating cycle.
    assign bus.stall_o = rst_ni & (
        ((r_state == S_IDLE) & bus.muldiv_en_i
            & !bus.flush_i)
        | (r_state == S_MUL)
        | (r_state == S_DIV));

    assign bus.busy_o   = r_busy;
    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl
// latency, results, flush and reset behaviour.
module tb_muldiv_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] last_res;

    muldiv_ctrl_if #(.XLEN(32)) bus ();

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit hit, required $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(
        input logic [2:0] f3,
        input logic [31:0] a,
        input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ubs;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic        ovf;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ubs = ub;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            3'd0: begin p = sa * sb;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * ubs; r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag,
                          input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp,
                          input int lat,
                          input bit hold);
        int cyc;
        int stalls;
        bus.muldiv_en_i = 1'b1;
        bus.funct3_i    = f3;
        bus.rs1_data_i  = a;
        bus.rs2_data_i  = b;
        #1;
        check({tag, "_stall_start"}, bus.stall_o, 1'b1);
        stalls = bus.stall_o ? 1 : 0;
        cyc = 0;
        while (!bus.valid_o && cyc < 40) begin
            tick();
            cyc++;
            if (!hold) begin
                bus.muldiv_en_i = 1'b0;
                bus.funct3_i    = 3'($urandom);
                bus.rs1_data_i  = $urandom;
                bus.rs2_data_i  = $urandom;
            end
            #1;
            if (!bus.valid_o && bus.stall_o) stalls++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, bus.result_o, exp);
        check({tag, "_done_stall"}, bus.stall_o, 1'b0);
        check({tag, "_done_busy"}, bus.busy_o, 1'b1);
        check({tag, "_stall_cycles"}, stalls, lat);
        last_res = exp;
        if (!hold) begin
            tick();
            check({tag, "_valid_drop"}, bus.valid_o, 1'b0);
            check({tag, "_busy_drop"}, bus.busy_o, 1'b0);
            check({tag, "_result_hold"}, bus.result_o, exp);
        end
    endtask

    initial begin
        int vcount;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int lat;
        checks   = 0;
        errors   = 0;
        last_res = '0;
        rst_n    = 1'b0;
        bus.muldiv_en_i = 1'b0;
        bus.funct3_i    = '0;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        bus.flush_i     = 1'b0;
        tick();
        tick();
        bus.muldiv_en_i = 1'b1;
        #1;
        check("rst_stall", bus.stall_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_result", bus.result_o, 32'h0);
        bus.muldiv_en_i = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_busy", bus.busy_o, 1'b0);

        run_op("mulh", 3'd1, 32'hFFFF_FFFE, 32'h3,
               32'hFFFF_FFFF, 33, 0);
        run_op("mul", 3'd0, 32'hFFFF_FFFE, 32'h3,
               32'hFFFF_FFFA, 33, 0);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 33, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 33, 0);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'h2,
               32'hFFFF_FFFD, 33, 0);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h2,
               32'hFFFF_FFFF, 33, 0);
        run_op("divu0", 3'd5, 32'h5, 32'h0,
               32'hFFFF_FFFF, 2, 0);
        run_op("remu0", 3'd7, 32'h5, 32'h0,
               32'h5, 2, 0);
        run_op("div0", 3'd4, 32'hFFFF_FFF9, 32'h0,
               32'hFFFF_FFFF, 2, 0);
        run_op("rem0", 3'd6, 32'hFFFF_FFF9, 32'h0,
               32'hFFFF_FFF9, 2, 0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 2, 0);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 2, 0);

        bus.muldiv_en_i = 1'b1;
        bus.funct3_i    = 3'd3;
        bus.rs1_data_i  = 32'h1234_5678;
        bus.rs2_data_i  = 32'h9ABC_DEF0;
        #1;
        tick();
        bus.muldiv_en_i = 1'b0;
        repeat (9) tick();
        check("flush_busy_before", bus.busy_o, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        #1;
        check("flush_busy", bus.busy_o, 1'b0);
        check("flush_stall", bus.stall_o, 1'b0);
        check("flush_valid", bus.valid_o, 1'b0);
        check("flush_result", bus.result_o, last_res);
        vcount = 0;
        repeat (40) begin
            tick();
            if (bus.valid_o) vcount++;
        end
        check("flush_no_valid", vcount, 0);

        bus.muldiv_en_i = 1'b1;
        bus.flush_i     = 1'b1;
        #1;
        check("flush_start_stall", bus.stall_o, 1'b0);
        tick();
        check("flush_start_busy", bus.busy_o, 1'b0);
        bus.muldiv_en_i = 1'b0;
        bus.flush_i     = 1'b0;
        tick();

        run_op("mul_hold", 3'd0, 32'hFFFF_FFFE, 32'h3,
               32'hFFFF_FFFA, 33, 1);
        tick();
        check("hold_one_pulse", bus.valid_o, 1'b0);
        check("hold_idle", bus.busy_o, 1'b0);
        run_op("mul_second", 3'd0, 32'hFFFF_FFFE, 32'h3,
               32'hFFFF_FFFA, 33, 0);

        bus.muldiv_en_i = 1'b1;
        bus.funct3_i    = 3'd4;
        bus.rs1_data_i  = 32'd100;
        bus.rs2_data_i  = 32'd7;
        #1;
        tick();
        bus.muldiv_en_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        bus.muldiv_en_i = 1'b1;
        #1;
        check("midrst_stall_in", bus.stall_o, 1'b0);
        tick();
        check("midrst_busy", bus.busy_o, 1'b0);
        check("midrst_valid", bus.valid_o, 1'b0);
        check("midrst_result", bus.result_o, 32'h0);
        check("midrst_stall", bus.stall_o, 1'b0);
        bus.muldiv_en_i = 1'b0;
        rst_n = 1'b1;
        vcount = 0;
        repeat (40) begin
            tick();
            if (bus.valid_o) vcount++;
        end
        check("midrst_no_valid", vcount, 0);
        last_res = '0;

        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            lat = 33;
            if (f3[2] && (b == 0 ||
                (!f3[0] && a == 32'h8000_0000 &&
                 b == 32'hFFFF_FFFF)))
                lat = 2;
            run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b,
                   ref_model(f3, a, b), lat, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
